// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Program counter and fetch stage ahead of instruction_memory.
//                Issues word addresses, captures the 1-cycle-latency read data
//                and presents {pc, instruction} to decode via valid/ready,
//                using a 2-entry FIFO to absorb backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_inflight_pc;

    logic [1:0]          r_count;
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [ADDR_W-1:0]   r_buf_pc    [0:1];
    logic [DATA_W-1:0]   r_buf_instr [0:1];

    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_occ;
    logic                w_issue;

    // Handshake and slot-accounting: the inflight fetch reserves a buffer slot
    // so a landing instruction can never overrun the FIFO.
    always_comb begin
        w_pop   = out_valid && out_ready;
        w_push  = r_inflight && !redirect_valid;
        w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue = (r_state == FETCH) && fetch_enable && !redirect_valid
                  && (w_occ < 3'd2);
    end

    // Next-state logic: fetch_enable alone steers the FSM, redirect does not.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (fetch_enable)  w_state_next = FETCH;
            FETCH:   if (!fetch_enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // PC and inflight tracking; a redirect reloads pc and kills the inflight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= c_reset_pc;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_inflight    <= 1'b0;
        end else if (w_issue) begin
            r_inflight_pc <= r_pc;
            r_inflight    <= 1'b1;
            r_pc          <= r_pc + c_pc_one;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    // Output FIFO: push returning instructions, pop on accept, flush on redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= 2'd0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_buf_pc[0]    <= '0;
            r_buf_pc[1]    <= '0;
            r_buf_instr[0] <= '0;
            r_buf_instr[1] <= '0;
        end else if (redirect_valid) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
                r_buf_instr[r_wr_ptr] <= imem_rdata;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_buf_instr[r_rd_ptr];
    assign out_pc    = r_buf_pc[r_rd_ptr];

endmodule
`default_nettype wire
